if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
Parametrised instruction buffer between the fetch stage and the decode stage. It is the multi-entry successor to the single-slot IF/ID latch.
- Holds up to DEPTH (pc, instruction) pairs in FIFO order.
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Clears in one cycle on an EX-stage branch redirect.
- Drops all-zero fetch words as bubbles instead of queuing them.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 32, pc width in bits
INST_W, 32, instruction width in bits
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global enable; 0 freezes all state
flush_in  input  1  branch redirect from EX; discards all entries
if_valid_in  input  1  fetch offers an entry this cycle
if_pc_in  input  ADDR_W  pc of offered entry
if_instru_in  input  INST_W  instruction of offered entry
if_ready_out  output  1  queue accepts an entry this cycle
id_ready_in  input  1  decode consumes head this cycle (0 = decode stalled)
id_valid_out  output  1  head entry is valid
id_pc_out  output  ADDR_W  head pc, 0 when empty
id_instru_out  output  INST_W  head instruction, 0 when empty
count_out  output  CNT_W  current occupancy, 0..DEPTH
full_out  output  1  count_out == DEPTH
empty_out  output  1  count_out == 0

Behaviour:
Clock, reset and enable
- One clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset: rd_ptr=0, wr_ptr=0, count=0.
  - Reset outputs: id_valid_out=0, id_pc_out=0, id_instru_out=0, count_out=0, full_out=0, empty_out=1, if_ready_out=1.
- rst_in has priority over rdy_in and flush_in. Reset mid-operation discards all entries in one cycle.
- rdy_in=0: no push, no pop, no flush; pointers, count and storage hold. Outputs keep their values.

Handshake
- push = rdy_in & if_valid_in & if_ready_out & !flush_in & (if_instru_in != 0).
- pop = rdy_in & id_valid_out & id_ready_in & !flush_in.
- if_ready_out = !full_out. This is combinational from count, with no dependence on id_ready_in.
- When full, a same-cycle pop does not let a push in.
- Zero instruction offered while ready: counts as accepted (handshake completes) but is not stored.

Flush
- flush_in=1 with rdy_in=1: next cycle count=0 and rd_ptr=wr_ptr=0. Any same-cycle push or pop is ignored.
- id_valid_out is driven combinationally from count, so it drops in the cycle after the flush edge.

Storage and pointers
- Register arrays pc_mem[DEPTH] and inst_mem[DEPTH].
- Write at wr_ptr on push. Head is read at rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.

Outputs and latency
- id_valid_out = (count != 0).
- id_pc_out / id_instru_out = head entry when valid, else 0. A zero output is a bubble for decode.
- Latency: entry pushed at edge N is visible on id_* after edge N (1 cycle) when the queue was empty. There is no combinational bypass from if_* to id_*.
- Simultaneous push and pop at count=1: head advances to the new entry. count stays 1.
- Simultaneous push and pop at 1 < count < DEPTH: count unchanged, both pointers advance.

Illegal cases
- Pop when empty cannot occur, because pop requires id_valid_out.
- Push when full cannot occur, because push requires if_ready_out.
- Inputs with X on if_* while if_valid_in=0 must not corrupt state.

Test Plan:
- Reset: hold rst_in=1 two cycles with if_valid_in=1 -> count_out=0, empty_out=1, id_valid_out=0, id_instru_out=0, if_ready_out=1.
- Fill/drain, DEPTH=4: push pc 0x0,0x4,0x8,0xC (instr 0x00000013) with id_ready_in=0 -> full_out=1, if_ready_out=0, fifth offer not taken. Then id_ready_in=1 -> id_pc_out sequence 0x0,0x4,0x8,0xC, then empty_out=1.
- Wrap and concurrency: continuous push and pop for 10 cycles starting at count=2 -> count_out stays 2, pcs emerge in order across pointer wrap, no loss or duplication.
- Flush: count=3 with push offered and id_ready_in=1 at flush_in=1 -> next cycle count_out=0, id_valid_out=0, the offered entry is absent; the following push appears 1 cycle later.
- rdy_in gating: count=2, rdy_in=0 for 3 cycles with if_valid_in=1, id_ready_in=1, flush_in=1 -> count_out, id_pc_out and pointers unchanged; on rdy_in=1 normal operation resumes.
- Zero word: offer if_instru_in=0 at pc 0x10 with if_ready_out=1 -> count_out unchanged, entry never appears on id_*.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID instruction queue.
// Combinational wiring only; no latency of its own.
// Backpressure travels as if_ready_out (fetch side) and id_ready_in (decode side).
interface if_id_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   // fetch -> queue
   logic              if_valid_in;
   logic [ADDR_W-1:0] if_pc_in;
   logic [INST_W-1:0] if_instru_in;
   logic              if_ready_out;
   // queue -> decode
   logic              id_ready_in;
   logic              id_valid_out;
   logic [ADDR_W-1:0] id_pc_out;
   logic [INST_W-1:0] id_instru_out;

   // the pipeline stages around the queue drive the requests and consume the head
   modport master (
      output if_valid_in, if_pc_in, if_instru_in, id_ready_in,
      input  if_ready_out, id_valid_out, id_pc_out, id_instru_out
   );

   // the queue itself
   modport slave (
      input  if_valid_in, if_pc_in, if_instru_in, id_ready_in,
      output if_ready_out, id_valid_out, id_pc_out, id_instru_out
   );
endinterface

// File: rtl/if_id_queue.sv
// FIFO of (pc, instruction) pairs between fetch and decode; drops zero words, one-cycle flush.
// Latency: an entry pushed at edge N is on id_* after edge N; no bypass path.
// Backpressure: if_ready_out = !full (independent of id_ready_in); rdy_in=0 freezes everything.
module if_id_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             flush_in,
   if_id_queue_if.slave     bus,
   output logic [CNT_W-1:0] count_out,
   output logic             full_out,
   output logic             empty_out
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   // Handshake qualification; zero words complete the handshake but are never stored.
   always_comb begin
      full_out         = (count == CNT_W'(DEPTH));
      empty_out        = (count == '0);
      bus.if_ready_out = !full_out;
      bus.id_valid_out = !empty_out;
      push = rdy_in && bus.if_valid_in && bus.if_ready_out && !flush_in
             && (bus.if_instru_in != '0);
      pop  = rdy_in && bus.id_valid_out && bus.id_ready_in && !flush_in;
   end

   // Head presentation: an empty queue shows an all-zero bubble to decode.
   always_comb begin
      bus.id_pc_out     = '0;
      bus.id_instru_out = '0;
      if (bus.id_valid_out) begin
         bus.id_pc_out     = pc_mem[rd_ptr];
         bus.id_instru_out = inst_mem[rd_ptr];
      end
   end

   assign count_out = count;

   // Pointer and occupancy update; reset beats flush beats push/pop, rdy_in gates all.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end
   end

   // Entry storage; needs no reset since occupancy alone decides what is visible.
   always_ff @(posedge clk_in) begin
      if (!rst_in && push) begin
         pc_mem[wr_ptr]   <= bus.if_pc_in;
         inst_mem[wr_ptr] <= bus.if_instru_in;
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Every expected value below is worked out by hand from the queue behaviour.
module tb_if_id_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int INST_W = 32;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic             rdy_in;
   logic             flush_in;
   logic [CNT_W-1:0] count_out;
   logic             full_out;
   logic             empty_out;

   int tests = 0;
   int fails = 0;

   if_id_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

   if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .flush_in  (flush_in),
      .bus       (bus.slave),
      .count_out (count_out),
      .full_out  (full_out),
      .empty_out (empty_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic vld, input logic [31:0] pc, input logic [31:0] ins);
      bus.if_valid_in  = vld;
      bus.if_pc_in     = pc;
      bus.if_instru_in = ins;
   endtask

   initial begin
      // reset held two cycles while fetch offers an entry
      rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; bus.id_ready_in = 1'b0;
      offer(1'b1, 32'h100, NOP);
      tick(); tick();
      chk("rst_count",   32'(count_out), 32'd0);
      chk("rst_empty",   32'(empty_out), 32'd1);
      chk("rst_full",    32'(full_out), 32'd0);
      chk("rst_valid",   32'(bus.id_valid_out), 32'd0);
      chk("rst_instru",  bus.id_instru_out, 32'd0);
      chk("rst_pc",      bus.id_pc_out, 32'd0);
      chk("rst_ifready", 32'(bus.if_ready_out), 32'd1);
      rst_in = 1'b0;

      // fill with decode stalled; the head is visible one edge after the first push
      for (int i = 0; i < DEPTH; i++) begin
         offer(1'b1, 32'(4 * i), NOP);
         tick();
         chk("fill_count", 32'(count_out), 32'(i + 1));
         chk("fill_head",  bus.id_pc_out, 32'd0);
      end
      chk("fill_full",    32'(full_out), 32'd1);
      chk("fill_ifready", 32'(bus.if_ready_out), 32'd0);
      chk("fill_instru",  bus.id_instru_out, NOP);
      offer(1'b1, 32'h10, NOP);
      tick();
      chk("fifth_refused", 32'(count_out), 32'd4);

      // full with a pop offered: the pop happens but the push is still refused
      bus.id_ready_in = 1'b1;
      tick();
      chk("full_pop_count", 32'(count_out), 32'd3);
      chk("full_pop_head",  bus.id_pc_out, 32'h4);

      // drain the remaining three in order
      offer(1'b0, 32'h0, 32'h0);
      for (int i = 1; i < DEPTH; i++) begin
         chk("drain_pc", bus.id_pc_out, 32'(4 * i));
         tick();
      end
      chk("drain_empty", 32'(empty_out), 32'd1);
      chk("drain_pc0",   bus.id_pc_out, 32'd0);

      // two entries queued, then ten cycles of push+pop across pointer wrap
      bus.id_ready_in = 1'b0;
      offer(1'b1, 32'h20, NOP); tick();
      offer(1'b1, 32'h24, NOP); tick();
      chk("wrap_start", 32'(count_out), 32'd2);
      bus.id_ready_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("wrap_head", bus.id_pc_out, 32'h20 + 32'(4 * k));
         offer(1'b1, 32'h28 + 32'(4 * k), NOP);
         tick();
         chk("wrap_count", 32'(count_out), 32'd2);
      end
      chk("wrap_end_head", bus.id_pc_out, 32'h48);

      // build count=3, then flush with a push and a pop offered in the same cycle
      bus.id_ready_in = 1'b0;
      offer(1'b1, 32'h50, NOP); tick();
      chk("pre_flush_count", 32'(count_out), 32'd3);
      flush_in = 1'b1; bus.id_ready_in = 1'b1;
      offer(1'b1, 32'h54, NOP);
      tick();
      chk("flush_count", 32'(count_out), 32'd0);
      chk("flush_valid", 32'(bus.id_valid_out), 32'd0);
      chk("flush_pc",    bus.id_pc_out, 32'd0);
      flush_in = 1'b0; bus.id_ready_in = 1'b0;
      offer(1'b1, 32'h58, NOP); tick();
      chk("post_flush_count", 32'(count_out), 32'd1);
      chk("post_flush_head",  bus.id_pc_out, 32'h58);

      // rdy_in low freezes state even with push, pop and flush all requested
      offer(1'b1, 32'h5C, NOP); tick();
      chk("gate_start", 32'(count_out), 32'd2);
      rdy_in = 1'b0; flush_in = 1'b1; bus.id_ready_in = 1'b1;
      offer(1'b1, 32'h60, NOP);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("gate_count", 32'(count_out), 32'd2);
         chk("gate_head",  bus.id_pc_out, 32'h58);
      end
      rdy_in = 1'b1; flush_in = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      tick();
      chk("resume_count", 32'(count_out), 32'd1);
      chk("resume_head",  bus.id_pc_out, 32'h5C);

      // zero word with the queue ready: handshake completes, nothing stored
      bus.id_ready_in = 1'b0;
      offer(1'b1, 32'h10, 32'h0);
      chk("zero_ifready", 32'(bus.if_ready_out), 32'd1);
      tick();
      chk("zero_count", 32'(count_out), 32'd1);
      chk("zero_head",  bus.id_pc_out, 32'h5C);
      offer(1'bx, 32'hx, 32'hx);
      offer(1'b0, 32'hx, 32'hx);
      bus.id_ready_in = 1'b1;
      tick();
      chk("zero_final_count", 32'(count_out), 32'd0);
      chk("zero_final_valid", 32'(bus.id_valid_out), 32'd0);
      chk("zero_final_pc",    bus.id_pc_out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
